// File: rtl/rf_pkg.sv
// Shared constants, state encoding and helpers for the multi-port register file.
// The sweep FSM and the top-level storage/scoreboard both import this package.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // popcount takes a fixed-width vector that callers zero-extend, so ADDR_W <= 8
  localparam int MAX_DEPTH  = 256;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_e;

  function automatic logic [31:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      cnt = cnt + {31'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Post-reset clear sweep: walks every register address once, writing zero,
// then parks in IDLE with rf_ready high until the next reset.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output rf_state_e         o_state,
  output logic              o_rf_ready,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  rf_state_e         r_state;
  rf_state_e         w_nextState;
  logic [ADDR_W-1:0] r_clrIdx;
  logic [ADDR_W-1:0] w_nextIdx;
  logic              r_ready;
  logic              w_nextReady;
  logic              w_clrWe;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= CLEAR;
      r_clrIdx <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_clrIdx <= w_nextIdx;
      r_ready  <= w_nextReady;
    end
  end

  // The last index is all-ones, so reaching it ends the sweep without wrapping
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_clrIdx;
    w_nextReady = r_ready;
    w_clrWe     = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clrWe = 1'b1;
        if (r_clrIdx == {ADDR_W{1'b1}}) begin
          w_nextState = IDLE;
          w_nextReady = 1'b1;
        end else begin
          w_nextIdx = r_clrIdx + 1'b1;
        end
      end
      IDLE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = CLEAR;
      end
    endcase
  end

  assign o_state    = r_state;
  assign o_rf_ready = r_ready;
  assign o_clr_we   = w_clrWe && !i_rst;
  assign o_clr_addr = r_clrIdx;

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module rf_mp_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_rf_ready,
  input  logic [NRD*ADDR_W-1:0] i_rd_addr,
  output logic [NRD*DATA_W-1:0] o_rd_data,
  output logic [NRD-1:0]        o_rd_busy,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_rsv_en,
  input  logic [ADDR_W-1:0]     i_rsv_addr,
  input  logic                  i_flush,
  output logic [ADDR_W:0]       o_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  rf_state_e         w_state;
  logic              w_isIdle;
  logic              w_clrWe;
  logic [ADDR_W-1:0] w_clrAddr;
  logic              w_zeroProt;
  logic              w_wrOk;
  logic              w_rsvOk;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  rf_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_state    (w_state),
    .o_rf_ready (o_rf_ready),
    .o_clr_we   (w_clrWe),
    .o_clr_addr (w_clrAddr)
  );

  assign w_isIdle   = (w_state == IDLE);
  assign w_zeroProt = (ZERO_REG != 0);
  assign w_wrOk     = w_isIdle && i_wr_en &&
                      (!w_zeroProt || (i_wr_addr != ADDR_W'(ZERO_ADDR)));
  assign w_rsvOk    = w_isIdle && i_rsv_en && !i_flush &&
                      (!w_zeroProt || (i_rsv_addr != ADDR_W'(ZERO_ADDR)));

  always_ff @(posedge i_clk) begin
    if (w_clrWe) begin
      r_mem[w_clrAddr] <= '0;
    end else if (w_wrOk) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Reserve is applied after the writeback clear so a same-address reserve wins
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else if (w_isIdle) begin
      if (i_flush) begin
        r_busy <= '0;
      end else if (w_wrOk) begin
        r_busy[i_wr_addr] <= 1'b0;
      end
      if (w_rsvOk) begin
        r_busy[i_rsv_addr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    logic [DATA_W-1:0] w_data;
    logic              w_busyBit;

    assign w_addr = i_rd_addr[g*ADDR_W +: ADDR_W];
    assign w_zero = w_zeroProt && (w_addr == ADDR_W'(ZERO_ADDR));

`ifdef RF_BYPASS_EN
    logic w_hit;
    assign w_hit     = w_wrOk && (i_wr_addr == w_addr);
    assign w_data    = w_hit ? i_wr_data : r_mem[w_addr];
    assign w_busyBit = w_hit ? (w_rsvOk && (i_rsv_addr == w_addr)) : r_busy[w_addr];
`else
    assign w_data    = r_mem[w_addr];
    assign w_busyBit = r_busy[w_addr];
`endif

    assign o_rd_data[g*DATA_W +: DATA_W] = (!w_isIdle || w_zero) ? '0 : w_data;
    assign o_rd_busy[g]                  = w_isIdle && !w_zero && w_busyBit;
  end

  assign o_busy_cnt = (ADDR_W+1)'(popcount(MAX_DEPTH'(r_busy)));

endmodule

// File: tb/tb_rf_mp_sb.sv
// Scoreboard bench for rf_mp_sb: directed slots push expected outputs into a
// queue and a negedge monitor pops and compares them against the DUT.
module tb_rf_mp_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 3;
  localparam int DEPTH  = 32;

  localparam logic [3:0] M_DATA = 4'b0001;
  localparam logic [3:0] M_BUSY = 4'b0010;
  localparam logic [3:0] M_CNT  = 4'b0100;
  localparam logic [3:0] M_RDY  = 4'b1000;
  localparam logic [3:0] M_ALL  = 4'b1111;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rfReady;
  logic [NRD*ADDR_W-1:0] rdAddr;
  logic [NRD*DATA_W-1:0] rdData;
  logic [NRD-1:0]        rdBusy;
  logic                  wrEn;
  logic [ADDR_W-1:0]     wrAddr;
  logic [DATA_W-1:0]     wrData;
  logic                  rsvEn;
  logic [ADDR_W-1:0]     rsvAddr;
  logic                  flush;
  logic [ADDR_W:0]       busyCnt;

  typedef struct {
    string                 name;
    logic [3:0]            mask;
    logic [NRD*DATA_W-1:0] data;
    logic [NRD-1:0]        busy;
    logic [ADDR_W:0]       cnt;
    logic                  ready;
  } expItem_t;

  expItem_t expQ[$];
  int checks = 0;
  int errors = 0;

  rf_mp_sb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_rf_ready (rfReady),
    .i_rd_addr  (rdAddr),
    .o_rd_data  (rdData),
    .o_rd_busy  (rdBusy),
    .i_wr_en    (wrEn),
    .i_wr_addr  (wrAddr),
    .i_wr_data  (wrData),
    .i_rsv_en   (rsvEn),
    .i_rsv_addr (rsvAddr),
    .i_flush    (flush),
    .o_busy_cnt (busyCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [NRD*DATA_W-1:0] pack3(input logic [DATA_W-1:0] d0,
                                                  input logic [DATA_W-1:0] d1,
                                                  input logic [DATA_W-1:0] d2);
    return {d2, d1, d0};
  endfunction

  function automatic logic [NRD*DATA_W-1:0] repData(input logic [DATA_W-1:0] v);
    return pack3(v, v, v);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic              wrEnV,
                               input logic [ADDR_W-1:0] wrAddrV,
                               input logic [DATA_W-1:0] wrDataV,
                               input logic              rsvEnV,
                               input logic [ADDR_W-1:0] rsvAddrV,
                               input logic              flushV);
    wrEn    = wrEnV;
    wrAddr  = wrAddrV;
    wrData  = wrDataV;
    rsvEn   = rsvEnV;
    rsvAddr = rsvAddrV;
    flush   = flushV;
  endtask

  task automatic setReads(input logic [ADDR_W-1:0] a0,
                          input logic [ADDR_W-1:0] a1,
                          input logic [ADDR_W-1:0] a2);
    rdAddr = {a2, a1, a0};
  endtask

  task automatic pushExp(input string                 name,
                         input logic [3:0]            mask,
                         input logic [NRD*DATA_W-1:0] data,
                         input logic [NRD-1:0]        busy,
                         input logic [ADDR_W:0]       cnt,
                         input logic                  ready);
    expItem_t e;
    e.name  = name;
    e.mask  = mask;
    e.data  = data;
    e.busy  = busy;
    e.cnt   = cnt;
    e.ready = ready;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expItem_t e);
    if (e.mask[0]) begin
      checks++;
      if (rdData !== e.data) begin
        errors++;
        $display("[TB] FAIL %s rd_data: got %h expected %h", e.name, rdData, e.data);
      end
    end
    if (e.mask[1]) begin
      checks++;
      if (rdBusy !== e.busy) begin
        errors++;
        $display("[TB] FAIL %s rd_busy: got %b expected %b", e.name, rdBusy, e.busy);
      end
    end
    if (e.mask[2]) begin
      checks++;
      if (busyCnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL %s busy_cnt: got %0d expected %0d", e.name, busyCnt, e.cnt);
      end
    end
    if (e.mask[3]) begin
      checks++;
      if (rfReady !== e.ready) begin
        errors++;
        $display("[TB] FAIL %s rf_ready: got %b expected %b", e.name, rfReady, e.ready);
      end
    end
  endtask

  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setReads(5'd5, 5'd5, 5'd5);

    for (int k = 0; k < 3; k++) begin
      cycle();
      pushExp($sformatf("resetHold%0d", k), M_ALL, repData('0), 3'b000, '0, 1'b0);
    end

    // Sweep after reset; a write/reserve to x5 mid-sweep must be ignored
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      cycle();
      if (k == 10) applyStimulus(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd5, 1'b0);
      else         applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
      pushExp($sformatf("sweep%0d", k), M_ALL, repData('0), 3'b000, '0, (k == DEPTH));
    end

    cycle();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
    setReads(5'd7, 5'd7, 5'd7);
    pushExp("rsv7Issue", M_ALL, repData('0), 3'b000, 6'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
      pushExp($sformatf("rsv7Wait%0d", k), M_ALL, repData('0), 3'b111, 6'd1, 1'b1);
    end
    cycle();
    applyStimulus(1'b1, 5'd7, 32'h1234, 1'b0, '0, 1'b0);
`ifdef RF_BYPASS_EN
    pushExp("wr7", M_ALL, repData(32'h1234), 3'b000, 6'd1, 1'b1);
`else
    pushExp("wr7", M_ALL, repData('0), 3'b111, 6'd1, 1'b1);
`endif
    cycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    pushExp("wr7After", M_ALL, repData(32'h1234), 3'b000, 6'd0, 1'b1);

    cycle();
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0);
    setReads(5'd0, 5'd0, 5'd0);
    pushExp("x0Write", M_ALL, repData('0), 3'b000, 6'd0, 1'b1);
    cycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    pushExp("x0After", M_ALL, repData('0), 3'b000, 6'd0, 1'b1);

    cycle();
    applyStimulus(1'b1, 5'd9, 32'hA5A5, 1'b1, 5'd9, 1'b0);
    setReads(5'd9, 5'd9, 5'd9);
`ifdef RF_BYPASS_EN
    pushExp("rsvWr9", M_ALL, repData(32'hA5A5), 3'b111, 6'd0, 1'b1);
`else
    pushExp("rsvWr9", M_ALL, repData('0), 3'b000, 6'd0, 1'b1);
`endif
    cycle();
    applyStimulus(1'b1, 5'd10, 32'h10, 1'b1, 5'd10, 1'b1);
    setReads(5'd9, 5'd10, 5'd7);
`ifdef RF_BYPASS_EN
    pushExp("flushSlot", M_ALL, pack3(32'hA5A5, 32'h10, 32'h1234), 3'b001, 6'd1, 1'b1);
`else
    pushExp("flushSlot", M_ALL, pack3(32'hA5A5, 32'h0, 32'h1234), 3'b001, 6'd1, 1'b1);
`endif
    cycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    pushExp("afterFlush", M_ALL, pack3(32'hA5A5, 32'h10, 32'h1234), 3'b000, 6'd0, 1'b1);

    cycle();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 1'b0);
    setReads(5'd3, 5'd3, 5'd3);
    pushExp("rsv3", M_ALL, repData('0), 3'b000, 6'd0, 1'b1);
    cycle();
    applyStimulus(1'b1, 5'd3, 32'h55, 1'b0, '0, 1'b0);
`ifdef RF_BYPASS_EN
    pushExp("wr3", M_ALL, repData(32'h55), 3'b000, 6'd1, 1'b1);
`else
    pushExp("wr3", M_ALL, repData('0), 3'b111, 6'd1, 1'b1);
`endif
    cycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    pushExp("wr3After", M_ALL, repData(32'h55), 3'b000, 6'd0, 1'b1);

    for (int j = 1; j < DEPTH; j++) begin
      cycle();
      applyStimulus(1'b0, '0, '0, 1'b1, ADDR_W'(j), 1'b0);
      pushExp($sformatf("rsvSweep%0d", j), M_CNT, repData('0), 3'b000, (ADDR_W+1)'(j - 1), 1'b1);
    end
    cycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setReads(5'd31, 5'd7, 5'd3);
    pushExp("allBusy", M_ALL, pack3(32'h0, 32'h1234, 32'h55), 3'b111, 6'd31, 1'b1);
    cycle();
    rst = 1'b1;
    pushExp("preReset", M_CNT | M_RDY, repData('0), 3'b000, 6'd31, 1'b1);
    cycle();
    rst = 1'b0;
    pushExp("postReset", M_ALL, repData('0), 3'b000, 6'd0, 1'b0);

    // Second sweep must clear the earlier contents and ignore a mid-sweep reserve
    for (int k = 1; k <= DEPTH; k++) begin
      cycle();
      if (k == 5) applyStimulus(1'b1, 5'd7, 32'hBEEF, 1'b1, 5'd7, 1'b0);
      else        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
      pushExp($sformatf("resweep%0d", k), M_ALL, repData('0), 3'b000, 6'd0, (k == DEPTH));
    end

    cycle();
    cycle();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queueDrain: got %0d pending expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
